// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS-subset control FSM with req/ack memory handshake, bus timeout,
// precise exceptions (reserved instr, bus error, interrupt) and a retire pulse.
module mc_ctrl_hs #(
  parameter int ALUOP_W = 3,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               mem_ack,
  input  logic               irq,
  input  logic               irq_en,
  output logic               mem_req,
  output logic               mem_we,
  output logic               ir_write,
  output logic               a_write,
  output logic               b_write,
  output logic               c_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic               regdst,
  output logic               extop,
  output logic               alusrc,
  output logic               memread,
  output logic               r31,
  output logic [ALUOP_W-1:0] aluop,
  output logic [2:0]         pc_sel,
  output logic               epc_write,
  output logic [1:0]         exc_cause,
  output logic               retire
);
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_EXC} state_e;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011,
    OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001, OP_ANDI = 6'b001100,
    OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUBU = 6'b100011,
    F_AND = 6'b100100, F_OR = 6'b100101, F_SLT = 6'b101010, F_JR = 6'b001000;
  localparam logic [ALUOP_W-1:0] A_ADD = ALUOP_W'(0), A_SUB = ALUOP_W'(1),
    A_AND = ALUOP_W'(2), A_OR = ALUOP_W'(3), A_SLT = ALUOP_W'(4), A_LUI = ALUOP_W'(5);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [5:0]      op_q, op_d, funct_q, funct_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      cause_q, cause_d;
  logic            ifent_q, ifent_d;
  logic            is_r, f_ok, op_ok, ext_imm, to_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      op_q    <= '0;
      funct_q <= '0;
      cnt_q   <= '0;
      cause_q <= '0;
      ifent_q <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      ifent_q <= ifent_d;
    end
  end

  // Decode strictly from the latched IR fields.
  always_comb begin
    is_r    = (op_q == OP_R);
    f_ok    = funct_q inside {F_ADD, F_ADDU, F_SUBU, F_AND, F_OR, F_SLT, F_JR};
    op_ok   = (is_r && f_ok) || (op_q inside {OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_ADDIU,
              OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW});
    ext_imm = op_q inside {OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ};
    to_hit  = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    funct_d   = funct_q;
    cnt_d     = '0;
    cause_d   = cause_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    a_write   = 1'b0;
    b_write   = 1'b0;
    c_write   = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    regdst    = 1'b0;
    extop     = 1'b0;
    alusrc    = 1'b0;
    memread   = 1'b0;
    r31       = 1'b0;
    aluop     = A_ADD;
    pc_sel    = 3'd0;
    epc_write = 1'b0;
    exc_cause = 2'd0;
    retire    = 1'b0;
    unique case (state_q)
      S_IF: begin
        if (ifent_q && irq && irq_en) begin
          state_d = S_EXC;
          cause_d = 2'd3;
        end else begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_write = 1'b1;
            op_d     = op;
            funct_d  = funct;
            state_d  = S_ID;
          end else if (to_hit) begin
            state_d = S_EXC;
            cause_d = 2'd2;
          end else cnt_d = cnt_q + 1'b1;
        end
      end
      S_ID: begin
        a_write = 1'b1;
        b_write = 1'b1;
        extop   = ext_imm;
        if (!op_ok) begin
          state_d = S_EXC;
          cause_d = 2'd1;
        end else if (op_q == OP_J) begin
          pc_sel   = 3'd1;
          pc_write = 1'b1;
          retire   = 1'b1;
          state_d  = S_IF;
        end else if (op_q == OP_JAL) begin
          pc_sel  = 3'd1;
          r31     = 1'b1;
          state_d = S_WB;
        end else state_d = S_EX;
      end
      S_EX: begin
        c_write = 1'b1;
        alusrc  = !(is_r || op_q == OP_BEQ);
        state_d = S_WB;
        case (op_q)
          OP_R: begin
            case (funct_q)
              F_SUBU:  aluop = A_SUB;
              F_AND:   aluop = A_AND;
              F_OR:    aluop = A_OR;
              F_SLT:   aluop = A_SLT;
              F_JR: begin
                pc_sel   = 3'd2;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = S_IF;
              end
              default: aluop = A_ADD;
            endcase
          end
          OP_ANDI: aluop = A_AND;
          OP_ORI:  aluop = A_OR;
          OP_LUI:  aluop = A_LUI;
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BEQ: begin
            aluop    = A_SUB;
            pc_sel   = 3'd3;
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_IF;
          end
          default: aluop = A_ADD;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OP_SW);
        if (mem_ack) begin
          if (op_q == OP_SW) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_IF;
          end else state_d = S_WB;
        end else if (to_hit) begin
          state_d = S_EXC;
          cause_d = 2'd2;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        regdst    = is_r;
        memread   = (op_q == OP_LW);
        r31       = (op_q == OP_JAL);
        state_d   = S_IF;
      end
      S_EXC: begin
        epc_write = 1'b1;
        pc_write  = 1'b1;
        pc_sel    = 3'd4;
        exc_cause = cause_q;
        state_d   = S_IF;
      end
      default: state_d = S_IF;
    endcase
    ifent_d = (state_d == S_IF) && (state_q != S_IF);
    // Outputs collapse while reset is held so an in-flight request drops at once.
    if (!rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      a_write   = 1'b0;
      b_write   = 1'b0;
      c_write   = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      regdst    = 1'b0;
      extop     = 1'b0;
      alusrc    = 1'b0;
      memread   = 1'b0;
      r31       = 1'b0;
      aluop     = A_ADD;
      pc_sel    = 3'd0;
      epc_write = 1'b0;
      exc_cause = 2'd0;
      retire    = 1'b0;
    end
  end
endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Scoreboard bench for mc_ctrl_hs: each driven cycle pushes its expected output word.
module tb_mc_ctrl_hs;
  logic clk = 1'b0, rst = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic mem_ack = 1'b0, irq = 1'b0, irq_en = 1'b0;
  logic mem_req, mem_we, ir_write, a_write, b_write, c_write, pc_write, reg_write;
  logic regdst, extop, alusrc, memread, r31, epc_write, retire;
  logic [2:0] aluop, pc_sel;
  logic [1:0] exc_cause;
  logic [22:0] obs;
  int n_chk = 0, n_pass = 0;
  string tagq[$];
  logic [22:0] expq[$];

  localparam logic [22:0] MREQ = 23'd1 << 22, MWE = 23'd1 << 21, IRW = 23'd1 << 20,
    AW = 23'd1 << 19, BW = 23'd1 << 18, CW = 23'd1 << 17, PCW = 23'd1 << 16,
    RW = 23'd1 << 15, RD = 23'd1 << 14, EXT = 23'd1 << 13, ASRC = 23'd1 << 12,
    MRD = 23'd1 << 11, R31 = 23'd1 << 10, EPC = 23'd1 << 3, RET = 23'd1;
  localparam logic [5:0] R = 6'h00, J = 6'h02, JAL = 6'h03, BEQ = 6'h04, ORI = 6'h0d,
    LUI = 6'h0f, LW = 6'h23, SW = 6'h2b;

  function automatic logic [22:0] al(input int v); return 23'(v) << 7; endfunction
  function automatic logic [22:0] ps(input int v); return 23'(v) << 4; endfunction
  function automatic logic [22:0] ca(input int v); return 23'(v) << 1; endfunction

  mc_ctrl_hs #(.ALUOP_W(3), .TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ack(mem_ack), .irq(irq),
    .irq_en(irq_en), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
    .a_write(a_write), .b_write(b_write), .c_write(c_write), .pc_write(pc_write),
    .reg_write(reg_write), .regdst(regdst), .extop(extop), .alusrc(alusrc),
    .memread(memread), .r31(r31), .aluop(aluop), .pc_sel(pc_sel),
    .epc_write(epc_write), .exc_cause(exc_cause), .retire(retire));

  assign obs = {mem_req, mem_we, ir_write, a_write, b_write, c_write, pc_write, reg_write,
                regdst, extop, alusrc, memread, r31, aluop, pc_sel, epc_write, exc_cause,
                retire};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called just after a rising edge; the word is compared on the falling edge.
  task automatic cyc(input string tag, input logic ack, input logic [22:0] e);
    mem_ack = ack;
    tagq.push_back(tag);
    expq.push_back(e);
    @(negedge clk);
    chk(tagq.pop_front(), obs, expq.pop_front());
    @(posedge clk);
    #1;
  endtask

  // Live IR fields are scrambled after the fetch so decode must use the latched copy.
  task automatic fetch(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input int waits);
    op = o;
    funct = f;
    for (int i = 0; i < waits; i++) cyc(tag, 1'b0, MREQ);
    cyc(tag, 1'b1, MREQ | IRW);
    op = 6'h3f;
    funct = 6'h3f;
  endtask

  initial begin
    #1;
    @(negedge clk);
    chk("reset_outs", obs, 23'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    fetch("addu_if", R, 6'h21, 0);
    cyc("addu_id", 1'b0, AW | BW);
    cyc("addu_ex", 1'b0, CW | al(0));
    cyc("addu_wb", 1'b0, RW | PCW | RD | RET);

    fetch("lw_if", LW, 6'h00, 0);
    cyc("lw_id", 1'b0, AW | BW | EXT);
    cyc("lw_ex", 1'b0, CW | ASRC | al(0));
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, MREQ);
    cyc("lw_mem_ack", 1'b1, MREQ);
    cyc("lw_wb", 1'b0, RW | PCW | MRD | RET);

    fetch("sw_if", SW, 6'h00, 0);
    cyc("sw_id", 1'b0, AW | BW | EXT);
    cyc("sw_ex", 1'b0, CW | ASRC | al(0));
    for (int i = 0; i < 16; i++) cyc("sw_mem_wait", 1'b0, MREQ | MWE);
    cyc("sw_exc", 1'b0, EPC | PCW | ps(4) | ca(2));

    fetch("sw2_if", SW, 6'h00, 2);
    cyc("sw2_id", 1'b0, AW | BW | EXT);
    cyc("sw2_ex", 1'b0, CW | ASRC | al(0));
    cyc("sw2_mem_ack", 1'b1, MREQ | MWE | PCW | RET);

    fetch("rsvd_if", 6'h3f, 6'h00, 0);
    cyc("rsvd_id", 1'b0, AW | BW);
    cyc("rsvd_exc", 1'b0, EPC | PCW | ps(4) | ca(1));
    fetch("badf_if", R, 6'h01, 0);
    cyc("badf_id", 1'b0, AW | BW);
    cyc("badf_exc", 1'b0, EPC | PCW | ps(4) | ca(1));

    fetch("subu_if", R, 6'h23, 0);
    cyc("subu_id", 1'b0, AW | BW);
    cyc("subu_ex", 1'b0, CW | al(1));
    cyc("subu_wb", 1'b0, RW | PCW | RD | RET);
    fetch("slt_if", R, 6'h2a, 0);
    cyc("slt_id", 1'b0, AW | BW);
    cyc("slt_ex", 1'b0, CW | al(4));
    cyc("slt_wb", 1'b0, RW | PCW | RD | RET);
    fetch("lui_if", LUI, 6'h00, 0);
    cyc("lui_id", 1'b0, AW | BW);
    cyc("lui_ex", 1'b0, CW | ASRC | al(5));
    cyc("lui_wb", 1'b0, RW | PCW | RET);
    fetch("j_if", J, 6'h00, 0);
    cyc("j_id", 1'b0, AW | BW | ps(1) | PCW | RET);
    fetch("jal_if", JAL, 6'h00, 0);
    cyc("jal_id", 1'b0, AW | BW | ps(1) | R31);
    cyc("jal_wb", 1'b0, RW | PCW | R31 | RET);
    fetch("jr_if", R, 6'h08, 0);
    cyc("jr_id", 1'b0, AW | BW);
    cyc("jr_ex", 1'b0, CW | ps(2) | PCW | RET);

    fetch("beq_if", BEQ, 6'h00, 0);
    cyc("beq_id", 1'b0, AW | BW | EXT);
    irq = 1'b1; irq_en = 1'b1;
    cyc("beq_ex", 1'b0, CW | al(1) | ps(3) | PCW | RET);
    cyc("irq_if", 1'b0, 23'd0);
    irq_en = 1'b0;
    cyc("irq_exc", 1'b0, EPC | PCW | ps(4) | ca(3));
    fetch("ori_if", ORI, 6'h00, 0);
    irq = 1'b0;
    cyc("ori_id", 1'b0, AW | BW);
    cyc("ori_ex", 1'b0, CW | ASRC | al(3));
    cyc("ori_wb", 1'b0, RW | PCW | RET);

    for (int i = 0; i < 16; i++) cyc("if_to_wait", 1'b0, MREQ);
    cyc("if_to_exc", 1'b0, EPC | PCW | ps(4) | ca(2));

    fetch("rlw_if", LW, 6'h00, 0);
    cyc("rlw_id", 1'b0, AW | BW | EXT);
    cyc("rlw_ex", 1'b0, CW | ASRC | al(0));
    cyc("rlw_mem_wait", 1'b0, MREQ);
    #2;
    chk("rlw_pre_rst", obs, MREQ);
    rst = 1'b0;
    #1;
    chk("rst_async_drop", obs, 23'd0);
    @(posedge clk); #1;
    chk("rst_held", obs, 23'd0);
    rst = 1'b1;
    cyc("rst_if", 1'b0, MREQ);
    fetch("post_if", R, 6'h24, 0);
    cyc("post_id", 1'b0, AW | BW);
    cyc("post_ex", 1'b0, CW | al(2));
    cyc("post_wb", 1'b0, RW | PCW | RD | RET);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_hs.md
Name: mc_ctrl_hs

Overview:
- Multi-cycle MIPS-subset control FSM, next generation of the core controller.
- Adds a req/ack memory handshake with wait states and bus-timeout, precise exceptions (reserved instruction, bus error, external interrupt), opcode/funct latching at fetch, and a retire pulse.
- Sits between the instruction register, the datapath enables and the unified memory port.

Parameters:
- ALUOP_W, 3, aluop width; codes ADD=0 SUB=1 AND=2 OR=3 SLT=4 LUI=5.
- TIMEOUT, 16, max wait cycles per memory access before bus error; 0 disables the timeout.
- TO_W, 5, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- op  in  6  IR[31:26]; sampled only when ir_write=1
- funct  in  6  IR[5:0]; sampled with op
- mem_ack  in  1  memory completes the current access this cycle
- irq  in  1  level interrupt request
- irq_en  in  1  interrupt enable
- mem_req  out  1  memory access request
- mem_we  out  1  store (valid with mem_req)
- ir_write, a_write, b_write, c_write, pc_write, reg_write  out  1 each  datapath enables
- regdst, extop, alusrc, memread, r31  out  1 each  datapath selects
- aluop  out  ALUOP_W  ALU operation
- pc_sel  out  3  0 none/PC+4, 1 J/JAL, 2 JR, 3 BEQ, 4 exception vector
- epc_write  out  1  capture current PC into EPC
- exc_cause  out  2  0 none, 1 reserved instr, 2 bus error, 3 interrupt; valid when epc_write=1
- retire  out  1  one-cycle pulse when an instruction completes

Behaviour:
- States: IF, ID, EX, MEM, WB, EXC. Reset gives state=IF, latched op/funct=0, timeout counter=0.
- Outputs are combinational from state, latched op/funct, mem_ack and the counter. Every enable, mem_req, epc_write and retire defaults to 0; pc_sel and exc_cause default to 0.
- Decode uses latched op/funct only, never the live inputs.
- IF entry priority: if irq&irq_en, go to EXC with cause 3; no fetch and no mem_req that cycle.
- IF otherwise:
  - mem_req=1, mem_we=0.
  - On mem_ack: ir_write=1, latch op/funct, go to ID.
  - Without mem_ack, stay in IF (wait state).
- Timeout:
  - The counter clears on entry to IF or MEM and increments each waiting cycle.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack, go to EXC with cause 2.
  - An ack arriving in that same cycle wins.
- ID: a_write=b_write=1; extop=1 for addi/addiu/lw/sw/beq, 0 for andi/ori/lui.
  - j: pc_sel=1, pc_write=1, retire=1, go to IF.
  - jal: pc_sel=1, r31=1, go to WB.
  - Undefined op, or R-type with undefined funct: go to EXC with cause 1; a_write and b_write still assert.
- EX: c_write=1, alusrc=1 except R-type/beq (0).
  - R funct: add/addu give ADD, subu SUB, and AND, or OR, slt SLT, then go to WB.
  - jr: pc_sel=2, pc_write=1, retire=1, go to IF.
  - addi/addiu give ADD, andi AND, ori OR, lui LUI, then go to WB.
  - lw/sw: ADD, go to MEM.
  - beq: SUB, pc_sel=3, pc_write=1, retire=1, go to IF.
- MEM: mem_req=1, mem_we=(op==sw), wait/timeout as in IF.
  - On ack, lw goes to WB.
  - On ack, sw gives pc_write=1, retire=1, go to IF.
  - A store is committed by memory on the ack cycle only.
- WB: reg_write=1, pc_write=1, retire=1, go to IF.
  - R-type: regdst=1.
  - I-type ALU ops: regdst=0.
  - lw: regdst=0, memread=1.
  - jal: r31=1.
- EXC (one cycle): epc_write=1, pc_write=1, pc_sel=4, exc_cause held from the detecting transition via a cause register, retire=0, go to IF.
  - irq is not re-taken until the next IF entry.
- Codes: op R=000000 j=000010 jal=000011 beq=000100 addi=001000 addiu=001001 andi=001100 ori=001101 lui=001111 lw=100011 sw=101011. funct add=100000 addu=100001 subu=100011 and=100100 or=100101 slt=101010 jr=001000.
- Reset mid-operation: immediate return to IF with all outputs 0 while rst=0; an in-flight mem_req drops asynchronously.

Test Plan:
- addu, mem_ack every cycle: IF,ID,EX,WB = 4 cycles; aluop=0 in EX; reg_write=regdst=retire=1 in WB.
- lw with mem_ack delayed 3 cycles in MEM: MEM held 4 cycles with mem_req=1, mem_we=0; then WB with memread=1; total 8 cycles.
- sw with mem_ack never asserted, TIMEOUT=16: exactly 16 MEM cycles, then EXC with exc_cause=2, epc_write=1, pc_sel=4; no retire.
- op=111111 fetched: ID to EXC with exc_cause=1; next state IF.
- irq=1, irq_en=1 at IF entry after beq retire: EXC cause 3 without mem_req; with irq_en=0 a normal fetch occurs.
- rst pulsed low during MEM wait of lw: state IF, mem_req=0 while low; after release, IF with mem_req=1 and latched op=0.
